// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised FIFO
// Purpose: read-mode constants and a constant clog2 used for pointer/count widths.
// Ports: none (package).
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Number of bits needed to address n entries (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - handshake/status bundle between a FIFO user and sync_fifo_param
// Purpose: groups the write, read, status and flag-clear signals of one FIFO.
// Ports (modport slave = FIFO side, master = user side):
//   write_enable, write_data, read_enable, flag_clear  : user -> FIFO
//   read_data, full, empty, almost_full, almost_empty,
//   count, overflow, underflow                         : FIFO -> user
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);

  localparam int CNT_W = clog2(DEPTH) + 1;

  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic              read_enable;
  logic [DATA_W-1:0] read_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic              flag_clear;

  modport master (
    output write_enable, write_data, read_enable, flag_clear,
    input  read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write_enable, write_data, read_enable, flag_clear,
    output read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - register-array dual-port memory, sync write / async read
// Purpose: DATA_W x DEPTH storage for sync_fifo_param; contents are never reset.
// Ports:
//   clk      in  write clock
//   i_we     in  write strobe
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  read address
//   o_rdata  out combinational read data at i_raddr
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with show-ahead option
// Purpose: pointers, occupancy count, threshold flags, sticky error flags and
//          read-mode selection around a fifo_mem_dp storage array.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of sync_fifo_param_if (write/read requests, data, status)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("sync_fifo_param: FWFT must be 0 or 1");
    end
  endgenerate

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_mem_rdata;

  // Acceptance looks only at this cycle's registered full/empty, so a
  // simultaneous read never makes room for a write and vice versa.
  assign w_wr_acc = bus.write_enable && !r_full;
  assign w_rd_acc = bus.read_enable && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Status flags are registered from the next count so they come straight
  // out of flops and cannot glitch, while still matching the registered count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == CW'(DEPTH));
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= CW'(AF_THRESH));
      r_almost_empty <= (w_count_nxt <= CW'(AE_THRESH));
      // A new error on the same edge as flag_clear wins.
      if (bus.write_enable && r_full) r_overflow <= 1'b1;
      else if (bus.flag_clear)        r_overflow <= 1'b0;
      if (bus.read_enable && r_empty) r_underflow <= 1'b1;
      else if (bus.flag_clear)        r_underflow <= 1'b0;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.write_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head of queue is visible directly; forced to zero while empty.
      assign bus.read_data = r_empty ? '0 : w_mem_rdata;
    end else begin : g_std
      logic [DATA_W-1:0] r_read_data;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_read_data <= '0;
        else if (w_rd_acc) r_read_data <= w_mem_rdata;
      end
      assign bus.read_data = r_read_data;
    end
  endgenerate

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (standard and show-ahead)
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) a_if ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) b_if ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) dut_std (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) dut_fwft (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int total = 0;
  int bad   = 0;

  int         a_cnt;
  int         b_cnt;
  bit         a_ovf;
  bit         a_udf;
  logic [7:0] a_rd;
  logic [7:0] a_sb[$];
  logic [7:0] b_sb[$];
  logic [7:0] b_exp;

  task automatic reset_models();
    a_cnt = 0; b_cnt = 0; a_ovf = 0; a_udf = 0; a_rd = 8'h00;
    a_sb.delete(); b_sb.delete();
  endtask

  task automatic idle_inputs();
    a_if.write_enable = 0; a_if.write_data = 0; a_if.read_enable = 0; a_if.flag_clear = 0;
    b_if.write_enable = 0; b_if.write_data = 0; b_if.read_enable = 0; b_if.flag_clear = 0;
  endtask

  // One clock on the standard-mode FIFO; the model decides acceptance from its own count.
  task automatic cyc_a(input bit we, input logic [7:0] wd, input bit re, input bit fc);
    bit wacc, racc;
    wacc = we && (a_cnt != 8);
    racc = re && (a_cnt != 0);
    a_if.write_enable = we; a_if.write_data = wd; a_if.read_enable = re; a_if.flag_clear = fc;
    @(posedge clk);
    if (racc) a_rd = a_sb.pop_front();
    if (wacc) a_sb.push_back(wd);
    a_cnt = a_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    if (we && !wacc) a_ovf = 1; else if (fc) a_ovf = 0;
    if (re && !racc) a_udf = 1; else if (fc) a_udf = 0;
    #1;
    idle_inputs();
  endtask

  // One clock on the show-ahead FIFO.
  task automatic cyc_b(input bit we, input logic [7:0] wd, input bit re);
    bit wacc, racc;
    logic [7:0] dummy;
    wacc = we && (b_cnt != 8);
    racc = re && (b_cnt != 0);
    b_if.write_enable = we; b_if.write_data = wd; b_if.read_enable = re;
    @(posedge clk);
    if (racc) dummy = b_sb.pop_front();
    if (wacc) b_sb.push_back(wd);
    b_cnt = b_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    b_exp = (b_sb.size() != 0) ? b_sb[0] : 8'h00;
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (a_if.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", a_if.empty); end
    total++; if (a_if.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", a_if.full); end
    total++; if (a_if.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_if.count); end
    total++; if (a_if.read_data !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", a_if.read_data); end
    total++; if (a_if.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", a_if.almost_full); end
    total++; if (a_if.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", a_if.almost_empty); end
    total++; if ({a_if.overflow, a_if.underflow} !== 2'b00) begin bad++; $display("FAIL reset_errflags got=%b exp=00", {a_if.overflow, a_if.underflow}); end
    total++; if (b_if.empty !== 1'b1 || b_if.read_data !== 8'h00) begin bad++; $display("FAIL reset_fwft got=%b/%h exp=1/00", b_if.empty, b_if.read_data); end
    #1 rst = 1'b0;
    reset_models();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1'b1, 8'(i), 1'b0, 1'b0);
      total++; if (a_if.count !== 4'(a_cnt)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", a_if.count, a_cnt); end
      total++; if (a_if.almost_full !== (a_cnt >= 6)) begin bad++; $display("FAIL fill_af cnt=%0d got=%b", a_cnt, a_if.almost_full); end
      total++; if (a_if.full !== (a_cnt == 8)) begin bad++; $display("FAIL fill_full cnt=%0d got=%b", a_cnt, a_if.full); end
      total++; if (a_if.empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", a_if.empty); end
    end
    cyc_a(1'b1, 8'h09, 1'b0, 1'b0);
    total++; if (a_if.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", a_if.overflow); end
    total++; if (a_if.count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", a_if.count); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (a_if.read_data !== a_rd) begin bad++; $display("FAIL drain_data got=%h exp=%h", a_if.read_data, a_rd); end
      total++; if (a_if.almost_empty !== (a_cnt <= 1)) begin bad++; $display("FAIL drain_ae cnt=%0d got=%b", a_cnt, a_if.almost_empty); end
    end
    total++; if (a_if.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", a_if.empty); end
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (a_if.underflow !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", a_if.underflow); end
    total++; if (a_if.read_data !== 8'h08) begin bad++; $display("FAIL udf_hold got=%h exp=08", a_if.read_data); end
    total++; if (a_if.overflow !== a_ovf) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", a_if.overflow, a_ovf); end
    cyc_a(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if ({a_if.overflow, a_if.underflow} !== 2'b00) begin bad++; $display("FAIL flag_clear got=%b exp=00", {a_if.overflow, a_if.underflow}); end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc_a(1'b1, 8'(8'h80 + 3 * i), 1'b1, 1'b0);
      total++; if (a_if.count !== 4'd4) begin bad++; $display("FAIL conc_count got=%0d exp=4", a_if.count); end
      total++; if (a_if.read_data !== a_rd) begin bad++; $display("FAIL conc_data got=%h exp=%h", a_if.read_data, a_rd); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (a_if.read_data !== a_rd) begin bad++; $display("FAIL conc_tail got=%h exp=%h", a_if.read_data, a_rd); end
    end
    total++; if (a_if.empty !== 1'b1 || a_if.underflow !== a_udf) begin bad++; $display("FAIL conc_end got=%b/%b exp=1/%b", a_if.empty, a_if.underflow, a_udf); end
  endtask

  task automatic test_fwft();
    total++; if (b_if.read_data !== 8'h00) begin bad++; $display("FAIL fwft_idle got=%h exp=00", b_if.read_data); end
    cyc_b(1'b1, 8'hA5, 1'b0);
    total++; if (b_if.empty !== 1'b0) begin bad++; $display("FAIL fwft_empty got=%b exp=0", b_if.empty); end
    total++; if (b_if.read_data !== 8'hA5) begin bad++; $display("FAIL fwft_show got=%h exp=a5", b_if.read_data); end
    cyc_b(1'b1, 8'h5A, 1'b1);
    total++; if (b_if.read_data !== b_exp || b_if.read_data !== 8'h5A) begin bad++; $display("FAIL fwft_next got=%h exp=5a", b_if.read_data); end
    cyc_b(1'b0, 8'h00, 1'b1);
    total++; if (b_if.empty !== 1'b1 || b_if.read_data !== b_exp) begin bad++; $display("FAIL fwft_drain got=%b/%h exp=1/%h", b_if.empty, b_if.read_data, b_exp); end
  endtask

  task automatic test_reset_edge();
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    total++; if (a_if.count !== 4'd5) begin bad++; $display("FAIL pre_rst_count got=%0d exp=5", a_if.count); end
    #2 rst = 1'b1;
    #1;
    total++; if (a_if.count !== 4'd0 || a_if.empty !== 1'b1) begin bad++; $display("FAIL midrst got=%0d/%b exp=0/1", a_if.count, a_if.empty); end
    #1 rst = 1'b0;
    reset_models();
    cyc_a(1'b1, 8'h3C, 1'b0, 1'b0);
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (a_if.read_data !== 8'h3C) begin bad++; $display("FAIL post_rst_data got=%h exp=3c", a_if.read_data); end
    for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc_a(1'b1, 8'hEE, 1'b0, 1'b1);
    total++; if (a_if.overflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", a_if.overflow); end
    total++; if (a_if.count !== 4'd8) begin bad++; $display("FAIL set_wins_count got=%0d exp=8", a_if.count); end
    cyc_a(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (a_if.overflow !== a_ovf) begin bad++; $display("FAIL clear_after got=%b exp=%b", a_if.overflow, a_ovf); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_models();
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_concurrent();
    test_fwft();
    test_reset_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the successor to the team's fixed 8-bit FIFO and is used wherever producer and consumer share one clock domain. It adds configurable width and depth, a show-ahead (first-word-fall-through) mode, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8: width of write_data and read_data in bits.
- DEPTH, 8: number of entries; must be a power of two and at least 4.
- FWFT, 0: read mode. 0 = standard registered read; 1 = show-ahead.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_enable  in  1  write request.
- write_data  in  DATA_W  data to write.
- read_enable  in  1  read request.
- read_data  out  DATA_W  data read from the FIFO.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  threshold flag (see AF_THRESH).
- almost_empty  out  1  threshold flag (see AE_THRESH).
- count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- flag_clear  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - write pointer = 0, read pointer = 0, count = 0.
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1.
  - overflow = 0, underflow = 0, read_data = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. The first edge after deassertion behaves as an empty FIFO.
- Write acceptance: write_enable && !full. The word is stored at the write pointer, and the write pointer advances modulo DEPTH.
- Read acceptance: read_enable && !empty. The read pointer advances modulo DEPTH.
- Acceptance uses only the current-cycle full/empty. A same-cycle read does not free space for a write. In standard mode, a same-cycle write does not make a read possible.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- Count arithmetic:
  - write only: +1.
  - read only: -1.
  - both accepted: unchanged.
  - neither: unchanged.
- Flags are decoded from the registered count. They are valid in the cycle after the accepting edge and are glitch-free.
- Standard mode (FWFT=0):
  - read_data is registered and takes mem[read pointer] on the edge that accepts a read. Latency is 1 cycle.
  - read_data holds its value when no read is accepted, including on underflow.
- Show-ahead mode (FWFT=1):
  - read_data = mem[read pointer] combinationally while !empty; 0 while empty.
  - A word written into an empty FIFO appears on read_data in the cycle after the write edge, together with empty deasserting.
  - An accepted read presents the next word in the following cycle.
- Overflow: write_enable && full sets overflow on that edge; the data is dropped and count is unchanged.
- Underflow: read_enable && empty sets underflow on that edge; the pointers are unchanged.
- flag_clear: clears both sticky flags on the edge. If a new error occurs on the same edge, set wins.
- Parameter checks (elaboration-time error):
  - DEPTH not a power of two, or DEPTH < 4.
  - AF_THRESH outside 1..DEPTH.
  - AE_THRESH outside 0..DEPTH-1.

Decomposition:
- fifo_pkg holds:
  - the clog2 constant function;
  - mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- One sub-module, fifo_mem_dp: a register-array dual-port memory (DATA_W x DEPTH) with a synchronous write port and an asynchronous read port.
- Pointer, count, flag and read-mode logic stay in sync_fifo_param.

Test Plan:
All scenarios use DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1 unless stated.
1. Reset: pulse rst between edges -> empty=1, full=0, count=0, read_data=0x00 immediately, without waiting for a clock edge.
2. Fill and overflow:
   - Write 0x01..0x08 on consecutive cycles -> almost_full=1 once count=6; full=1 once count=8.
   - 9th write of 0x09 -> overflow=1, count stays 8, 0x09 is dropped.
3. Drain and underflow (FWFT=0):
   - 8 reads -> read_data = 0x01..0x08, each 1 cycle after its read; empty=1 after the last.
   - 9th read -> underflow=1, read_data holds 0x08.
   - flag_clear -> overflow=0 and underflow=0.
4. Concurrent traffic and wrap-around:
   - At count=4, simultaneous read and write for 20 cycles -> count stays 4.
   - Output sequence matches input order across at least two pointer wraps.
5. Show-ahead (FWFT=1):
   - Write 0xA5 into an empty FIFO -> next cycle empty=0 and read_data=0xA5 with no read_enable.
   - Then write 0x5A and read once -> read_data=0x5A on the next cycle.
6. Reset and clear edge cases:
   - Assert rst at count=5 -> count=0 and empty=1 at once; the next write/read of 0x3C returns 0x3C.
   - flag_clear on the same edge as a write while full -> overflow remains 1.
